// File: rtl/spmv_csr_engine_pkg.sv
// spmv_csr_engine_pkg: shared FSM encoding and fp16 constants for the CSR SpMV engine.
package spmv_csr_engine_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MUL, S_ADD, S_WRITE, S_DONE} state_t;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [4:0]  FP16_EMAX = 5'h1f;
  localparam int          PTR_W_DEF = 8;
endpackage

// File: rtl/SpMV_fp16_add.sv
// SpMV_fp16_add: combinational fp16 add, round-to-nearest-even, subnormals flushed to zero.
module SpMV_fp16_add
  import spmv_csr_engine_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] s_o
);
  logic swap, sub, g, st, a_inf, b_inf, a_nan, b_nan, a_z, b_z;
  logic [15:0] x, yv;
  logic [4:0] d;
  logic [13:0] mx, my, my_sh, n;
  logic [14:0] s;
  logic [3:0] lz;
  logic [9:0] mant;
  logic [10:0] rnd;
  logic signed [6:0] e;
  always_comb begin
    a_inf = a_i[14:10] == FP16_EMAX;
    b_inf = b_i[14:10] == FP16_EMAX;
    a_nan = a_inf && a_i[9:0] != 10'd0;
    b_nan = b_inf && b_i[9:0] != 10'd0;
    a_z = a_i[14:10] == 5'd0;
    b_z = b_i[14:10] == 5'd0;
    swap = b_i[14:0] > a_i[14:0];
    x = swap ? b_i : a_i;
    yv = swap ? a_i : b_i;
    d = x[14:10] - yv[14:10];
    mx = {1'b1, x[9:0], 3'b0};
    my = {1'b1, yv[9:0], 3'b0};
    // the smaller operand keeps guard/round bits plus a sticky bit for everything shifted out
    my_sh = (d > 5'd13) ? 14'd1 : (my >> d) | {13'd0, |(my & ((14'd1 << d) - 14'd1))};
    sub = x[15] ^ yv[15];
    s = sub ? {1'b0, mx} - {1'b0, my_sh} : {1'b0, mx} + {1'b0, my_sh};
    n = s[14] ? (s[14:1] | {13'd0, s[0]}) : s[13:0];
    e = $signed({2'b0, x[14:10]}) + $signed({6'b0, s[14]});
    lz = 4'd0;
    for (int i = 0; i < 14; i++) if (n[i]) lz = 4'(13 - i);
    n = n << lz;
    e = e - $signed({3'b0, lz});
    mant = n[12:3];
    g = n[2];
    st = |n[1:0];
    rnd = {1'b0, mant} + {10'd0, g & (st | mant[0])};
    e = e + $signed({6'b0, rnd[10]});
    s_o = (a_nan || b_nan || (a_inf && b_inf && sub)) ? FP16_QNAN :
          a_inf ? a_i : b_inf ? b_i :
          (a_z && b_z) ? {a_i[15] & b_i[15], 15'h0} :
          a_z ? b_i : b_z ? a_i :
          (s == 15'd0) ? FP16_ZERO :
          (e >= 7'sd31) ? {x[15], FP16_EMAX, 10'h0} :
          (e <= 7'sd0) ? {x[15], 15'h0} : {x[15], e[4:0], rnd[9:0]};
  end
endmodule

// File: rtl/SpMV_fp16_mul.sv
// SpMV_fp16_mul: combinational fp16 multiply, round-to-nearest-even, subnormals flushed to zero.
module SpMV_fp16_mul
  import spmv_csr_engine_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] p_o
);
  logic [4:0] ea, eb;
  logic sgn, hi, g, st, a_inf, b_inf, a_nan, b_nan, a_z, b_z;
  logic [21:0] prod;
  logic [9:0] mant;
  logic [10:0] rnd;
  logic signed [7:0] e;
  always_comb begin
    ea = a_i[14:10];
    eb = b_i[14:10];
    sgn = a_i[15] ^ b_i[15];
    a_inf = ea == FP16_EMAX;
    b_inf = eb == FP16_EMAX;
    a_nan = a_inf && a_i[9:0] != 10'd0;
    b_nan = b_inf && b_i[9:0] != 10'd0;
    a_z = ea == 5'd0;
    b_z = eb == 5'd0;
    prod = {11'd0, 1'b1, a_i[9:0]} * {11'd0, 1'b1, b_i[9:0]};
    hi = prod[21];
    mant = hi ? prod[20:11] : prod[19:10];
    g = hi ? prod[10] : prod[9];
    st = hi ? |prod[9:0] : |prod[8:0];
    rnd = {1'b0, mant} + {10'd0, g & (st | mant[0])};
    e = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 8'sd15 + $signed({7'b0, hi}) + $signed({7'b0, rnd[10]});
    p_o = (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) ? FP16_QNAN :
          (a_inf || b_inf) ? {sgn, FP16_EMAX, 10'h0} :
          (a_z || b_z) ? {sgn, 15'h0} :
          (e >= 8'sd31) ? {sgn, FP16_EMAX, 10'h0} :
          (e <= 8'sd0) ? {sgn, 15'h0} : {sgn, e[4:0], rnd[9:0]};
  end
endmodule

// File: rtl/spmv_csr_engine_row_tracker.sv
// spmv_csr_engine_row_tracker: consumed-element count k and current CSR row, with end/skip flags.
module spmv_csr_engine_row_tracker #(
  parameter int N_ROWS = 16,
  parameter int PTR_W  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_clr,
  input  logic                        i_fetch,
  input  logic                        i_accept,
  input  logic [(N_ROWS+1)*PTR_W-1:0] i_row_ptr,
  output logic [$clog2(N_ROWS)-1:0]   o_row,
  output logic                        o_at_end,
  output logic                        o_skip
);
  localparam int RW = $clog2(N_ROWS);
  logic [RW-1:0] row_q, row_d;
  logic [PTR_W-1:0] k_q, k_d, nnz, ptr_nxt;
  logic [RW:0] nxt_idx;
  assign nnz = i_row_ptr[N_ROWS*PTR_W +: PTR_W];
  assign nxt_idx = {1'b0, row_q} + 1'b1;
  assign ptr_nxt = i_row_ptr[nxt_idx*PTR_W +: PTR_W];
  assign o_at_end = k_q == nnz;
  // the last row never advances, so a malformed row_ptr parks extra elements there
  assign o_skip = ptr_nxt <= k_q && row_q != RW'(N_ROWS - 1);
  assign o_row = row_q;
  always_comb begin
    row_d = i_clr ? '0 : (i_fetch && !o_at_end && o_skip) ? row_q + 1'b1 : row_q;
    k_d = i_clr ? '0 : i_accept ? k_q + 1'b1 : k_q;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_q <= '0;
      k_q <= '0;
    end else begin
      row_q <= row_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/spmv_csr_engine.sv
// spmv_csr_engine: CSR sparse-matrix x dense-vector engine, one fp16 nonzero per four cycles.
module spmv_csr_engine
  import spmv_csr_engine_pkg::*;
#(
  parameter int N_ROWS = 16,
  parameter int DW     = 16,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [(N_ROWS+1)*PTR_W-1:0] i_row_ptr,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DW-1:0]               i_val,
  input  logic [DW-1:0]               i_vec,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [N_ROWS*DW-1:0]        o_y
);
  state_t state_q;
  logic [DW-1:0] val_q, vec_q, prod_q, sum_q, prod, sum;
  logic [DW-1:0] y_q [N_ROWS];
  logic [$clog2(N_ROWS)-1:0] row;
  logic at_end, skip, fetch, accept, done_q;
  assign fetch = state_q == S_FETCH;
  assign o_ready = fetch && !at_end && !skip;
  assign accept = o_ready && i_valid;
  assign o_busy = state_q != S_IDLE;
  assign o_done = done_q;
  spmv_csr_engine_row_tracker #(.N_ROWS(N_ROWS), .PTR_W(PTR_W)) u_trk (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(state_q == S_IDLE && i_start),
    .i_fetch(fetch), .i_accept(accept), .i_row_ptr(i_row_ptr),
    .o_row(row), .o_at_end(at_end), .o_skip(skip)
  );
  SpMV_fp16_mul u_mul (.a_i(val_q), .b_i(vec_q), .p_o(prod));
  SpMV_fp16_add u_add (.a_i(y_q[row]), .b_i(prod_q), .s_o(sum));
  for (genvar g = 0; g < N_ROWS; g++) begin : g_y
    assign o_y[g*DW +: DW] = y_q[g];
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      val_q <= '0;
      vec_q <= '0;
      prod_q <= '0;
      sum_q <= '0;
      done_q <= 1'b0;
      for (int r = 0; r < N_ROWS; r++) y_q[r] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          state_q <= S_FETCH;
          for (int r = 0; r < N_ROWS; r++) y_q[r] <= FP16_ZERO;
        end
        S_FETCH: if (at_end) begin
          state_q <= S_DONE;
          done_q <= 1'b1;
        end else if (accept) begin
          val_q <= i_val;
          vec_q <= i_vec;
          state_q <= S_MUL;
        end
        S_MUL: begin
          prod_q <= prod;
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q <= sum;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          y_q[row] <= sum_q;
          state_q <= S_FETCH;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spmv_csr_engine.sv
// tb_spmv_csr_engine: directed and randomized jobs checked against an integer CSR model.
module tb_spmv_csr_engine;
  localparam int NR = 16, DW = 16, PW = 8;
  logic clk = 1'b0, rstn, start, valid, ready, busy, done;
  logic [(NR+1)*PW-1:0] row_ptr;
  logic [DW-1:0] val, vec;
  logic [NR*DW-1:0] y;
  int errors = 0, checks = 0;
  int ptr[NR+1];
  int qa[$], qb[$];
  int idx, lat, done_cnt, rdy_cnt;
  always #5 clk = ~clk;
  spmv_csr_engine #(.N_ROWS(NR), .DW(DW), .PTR_W(PW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_row_ptr(row_ptr),
    .i_valid(valid), .o_ready(ready), .i_val(val), .i_vec(vec),
    .o_busy(busy), .o_done(done), .o_y(y)
  );
  // exact fp16 encoding of a small integer (|v| < 2048)
  function automatic logic [15:0] to_fp16(input int v);
    int m, p;
    logic [15:0] r;
    if (v == 0) return 16'h0000;
    m = v < 0 ? -v : v;
    p = 0;
    for (int i = 0; i < 11; i++) if ((m >> i) != 0) p = i;
    r[15] = v < 0;
    r[14:10] = 5'(15 + p);
    r[9:0] = 10'((m << (10 - p)) & 'h3ff);
    return r;
  endfunction
  function automatic int row_of(input int j);
    int c = 0;
    for (int r = 1; r < NR; r++) if (ptr[r] <= j) c++;
    return c;
  endfunction
  function automatic int exp_lat(input int extra);
    return qa.size() == 0 ? 2 + extra : 4 * qa.size() + row_of(qa.size() - 1) + 2 + extra;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_job(input int p[NR+1], input int a[$], input int b[$]);
    ptr = p;
    qa = a;
    qb = b;
    for (int r = 0; r <= NR; r++) row_ptr[r*PW +: PW] = PW'(ptr[r]);
  endtask
  task automatic start_job();
    idx = 0;
    done_cnt = 0;
    rdy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drive(input int stop_at, input int stall, input int gap_pct, input bit noise);
    int t = 1;
    int st = stall;
    logic acc;
    lat = -1;
    while (t < 3000) begin
      if (done) begin
        done_cnt++;
        lat = t;
        break;
      end
      if (idx == stop_at) break;
      if (ready) rdy_cnt++;
      if (st > 0) begin
        chk("stall_ready", 32'(ready), 1);
        chk("stall_y0", 32'(y[DW-1:0]), 0);
        st--;
        valid = 1'b0;
      end else valid = idx < qa.size() && $urandom_range(99) >= gap_pct;
      val = idx < qa.size() ? to_fp16(qa[idx]) : 16'($urandom);
      vec = idx < qb.size() ? to_fp16(qb[idx]) : 16'($urandom);
      start = noise && $urandom_range(3) == 0;
      acc = ready && valid;
      @(negedge clk);
      t++;
      if (acc) idx++;
    end
    start = 1'b0;
    valid = 1'b0;
  endtask
  task automatic check_y(input string tag);
    int ym[NR];
    foreach (ym[r]) ym[r] = 0;
    foreach (qa[j]) ym[row_of(j)] += qa[j] * qb[j];
    for (int r = 0; r < NR; r++) chk($sformatf("%s_y%0d", tag, r), 32'(y[r*DW +: DW]), 32'(to_fp16(ym[r])));
  endtask
  task automatic finish_job(input string tag, input int elat, input int erdy);
    chk({tag, "_done_seen"}, 32'(lat > 0), 1);
    if (elat >= 0) chk({tag, "_latency"}, lat, elat);
    if (erdy >= 0) chk({tag, "_ready_cycles"}, rdy_cnt, erdy);
    chk({tag, "_consumed"}, idx, qa.size());
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle"}, 32'(busy), 0);
    check_y(tag);
  endtask
  initial begin
    int p[NR+1];
    int a[$], b[$], tmp[$];
    int nnz;
    rstn = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    val = '0;
    vec = '0;
    row_ptr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_y", 32'(|y), 0);
    rstn = 1'b1;
    // nnz = 0: done two cycles after start, ready never asserted
    foreach (p[r]) p[r] = 0;
    a = {};
    b = {};
    set_job(p, a, b);
    start_job();
    drive(-1, 0, 0, 1'b0);
    finish_job("empty", 2, 0);
    // one row with two nonzeros
    foreach (p[r]) p[r] = 2;
    p[0] = 0;
    set_job(p, '{1, 1}, '{2, 3});
    start_job();
    drive(-1, 0, 0, 1'b0);
    finish_job("row0", exp_lat(0), 2);
    chk("row0_const", 32'(y[15:0]), 32'h4500);
    // empty rows between nonzeros
    foreach (p[r]) p[r] = 2;
    p[0] = 0;
    p[1] = 1;
    p[2] = 1;
    set_job(p, '{1, 2}, '{2, 3});
    start_job();
    drive(-1, 0, 0, 1'b0);
    finish_job("skip", exp_lat(0), 2);
    chk("skip_y2_const", 32'(y[47:32]), 32'h4600);
    // producer stalls five cycles in FETCH
    foreach (p[r]) p[r] = 2;
    p[0] = 0;
    set_job(p, '{1, 1}, '{2, 3});
    start_job();
    drive(-1, 5, 0, 1'b0);
    finish_job("stall", exp_lat(5), 7);
    // reset while the second product sits in ADD, then rerun
    start_job();
    drive(2, 0, 0, 1'b0);
    chk("abort_partial_y0", 32'(y[15:0]), 32'h4000);
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("abort_y", 32'(|y), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(ready), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done), 0);
    start_job();
    drive(-1, 0, 0, 1'b0);
    finish_job("rerun", exp_lat(0), 2);
    // row_ptr all zero but nnz=3: row saturates and everything lands in the last row
    foreach (p[r]) p[r] = 0;
    p[NR] = 3;
    set_job(p, '{3, -2, 7}, '{4, 5, -1});
    start_job();
    drive(-1, 0, 0, 1'b0);
    finish_job("sat", exp_lat(0), 3);
    // random monotonic jobs with producer gaps and stray start pulses
    for (int n = 0; n < 8; n++) begin
      nnz = $urandom_range(0, 30);
      tmp = {};
      for (int r = 1; r < NR; r++) tmp.push_back($urandom_range(0, nnz));
      tmp.sort();
      p[0] = 0;
      p[NR] = nnz;
      for (int r = 1; r < NR; r++) p[r] = tmp[r-1];
      a = {};
      b = {};
      for (int j = 0; j < nnz; j++) begin
        a.push_back(int'($urandom_range(0, 14)) - 7);
        b.push_back(int'($urandom_range(0, 14)) - 7);
      end
      set_job(p, a, b);
      start_job();
      drive(-1, 0, 30, 1'b1);
      finish_job($sformatf("rnd%0d", n), -1, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
